// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: operand forwarding mux, funct3 compare, target adder,
// load-use stall FSM and registered redirect. Optional BRANCH_STATS_EN adds stats counters.
module branch_resolve_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic            ex_is_load,
    input  logic            mem_is_load,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      mem_rd,
    output logic            stall_id,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if,
    output logic            illegal_br
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     br_taken_cnt,
    output logic [31:0]     br_ntaken_cnt,
    output logic [31:0]     br_stall_cnt
`endif
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t          state, state_nxt;
    logic [1:0]      cnt, cnt_nxt;
    logic            resolve;
    logic            taken;
    logic            illegal;
    logic            is_branch;
    logic            hz_ex, hz_mem;
    logic [4:0]      rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;

    assign rs1       = id_inst[19:15];
    assign rs2       = id_inst[24:20];
    assign funct3    = id_inst[14:12];
    assign is_branch = id_valid && (id_inst[6:0] == 7'b1100011);
    assign hz_ex     = ex_is_load && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
    assign hz_mem    = mem_is_load && (mem_rd != 5'd0) && ((mem_rd == rs1) || (mem_rd == rs2));

    // Select 11 is reserved and falls back to the register file.
    assign op_a = (fwd_a == 2'b01) ? mem_result : (fwd_a == 2'b10) ? ex_result : rs1_data;
    assign op_b = (fwd_b == 2'b01) ? mem_result : (fwd_b == 2'b10) ? ex_result : rs2_data;

    assign imm     = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
    assign target  = id_pc + imm;
    assign illegal = (funct3[2:1] == 2'b01);

    // NOTE: every signal written in an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b100:  taken = ($signed(op_a) <  $signed(op_b));
            3'b101:  taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  taken = (op_a <  op_b);
            3'b111:  taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_id  = 1'b0;
        resolve   = 1'b0;
        case (state)
            IDLE: begin
                // A branch behind a taken redirect is on the wrong path.
                if (is_branch && !redirect_valid) begin
                    if (hz_ex) begin
                        stall_id  = 1'b1;
                        cnt_nxt   = 2'd1;
                        state_nxt = STALL;
                    end else if (hz_mem) begin
                        stall_id  = 1'b1;
                        cnt_nxt   = 2'd0;
                        state_nxt = STALL;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            STALL: begin
                if (!is_branch) begin
                    state_nxt = IDLE;
                end else if (cnt != 2'd0) begin
                    stall_id = 1'b1;
                    cnt_nxt  = cnt - 2'd1;
                end else begin
                    resolve   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            redirect_valid <= 1'b0;
            flush_if       <= 1'b0;
            redirect_pc    <= '0;
            illegal_br     <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            redirect_valid <= resolve && taken;
            flush_if       <= resolve && taken;
            illegal_br     <= resolve && illegal;
            if (resolve && taken) redirect_pc <= target;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_taken_cnt  <= '0;
            br_ntaken_cnt <= '0;
            br_stall_cnt  <= '0;
        end else begin
            if (resolve && taken && (br_taken_cnt != '1))
                br_taken_cnt <= br_taken_cnt + 32'd1;
            if (resolve && !taken && (br_ntaken_cnt != '1))
                br_ntaken_cnt <= br_ntaken_cnt + 32'd1;
            if (stall_id && (br_stall_cnt != '1))
                br_stall_cnt <= br_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model of the branch rules.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst, id_pc;
    logic [31:0] rs1_data, rs2_data, ex_result, mem_result;
    logic [1:0]  fwd_a, fwd_b;
    logic        ex_is_load, mem_is_load;
    logic [4:0]  ex_rd, mem_rd;
    logic        stall_id, redirect_valid, flush_if, illegal_br;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_taken_cnt, br_ntaken_cnt, br_stall_cnt;
`endif

    branch_resolve_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result), .mem_result(mem_result),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .stall_id(stall_id), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_if(flush_if), .illegal_br(illegal_br)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(br_taken_cnt), .br_ntaken_cnt(br_ntaken_cnt), .br_stall_cnt(br_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: expected registered outputs and an outstanding stalled branch.
    logic        m_rv = 1'b0;
    logic        m_ill = 1'b0;
    logic [31:0] m_pc = 32'd0;
    bit          pending = 1'b0;
    int          need = 0;
    int          done = 0;
    logic        last_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] make_br(input logic [2:0] f3, input logic [4:0] r1,
                                            input logic [4:0] r2, input logic [12:0] imm);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] operand(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return mem_result;
        if (sel == 2'b10) return ex_result;
        return rf;
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Compare the DUT with the model for the current cycle, then advance the model.
    task automatic model_cycle();
        bit          is_br, hz_ex, hz_mem, do_res, e_stall, tk;
        logic [4:0]  r1, r2;
        logic [12:0] off;
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
        check("flush_if", {31'd0, flush_if}, {31'd0, m_rv});
        check("redirect_pc", redirect_pc, m_pc);
        check("illegal_br", {31'd0, illegal_br}, {31'd0, m_ill});
        if (rst) begin
            m_rv = 1'b0; m_ill = 1'b0; m_pc = 32'd0; pending = 1'b0;
            return;
        end
        is_br   = id_valid && (id_inst[6:0] == 7'b1100011);
        r1      = id_inst[19:15];
        r2      = id_inst[24:20];
        hz_ex   = ex_is_load && ex_rd != 0 && (ex_rd == r1 || ex_rd == r2);
        hz_mem  = mem_is_load && mem_rd != 0 && (mem_rd == r1 || mem_rd == r2);
        do_res  = 1'b0;
        e_stall = 1'b0;
        if (pending) begin
            if (!is_br) pending = 1'b0;
            else if (done < need) begin e_stall = 1'b1; done++; end
            else begin do_res = 1'b1; pending = 1'b0; end
        end else if (is_br && !m_rv) begin
            if (hz_ex || hz_mem) begin
                need = hz_ex ? 2 : 1; done = 1; e_stall = 1'b1; pending = 1'b1;
            end else begin
                do_res = 1'b1;
            end
        end
        check("stall_id", {31'd0, stall_id}, {31'd0, e_stall});
        tk    = branch_taken(id_inst[14:12], operand(fwd_a, rs1_data), operand(fwd_b, rs2_data));
        off   = {id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
        m_ill = do_res && (id_inst[14:12] == 3'd2 || id_inst[14:12] == 3'd3);
        m_rv  = do_res && tk;
        if (m_rv) m_pc = id_pc + {{19{off[12]}}, off};
    endtask

    task automatic step();
        @(negedge clk);
        last_stall = stall_id;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_inst = 32'h0000_0013; id_pc = 0;
        rs1_data = 0; rs2_data = 0; ex_result = 0; mem_result = 0;
        fwd_a = 0; fwd_b = 0; ex_is_load = 0; mem_is_load = 0; ex_rd = 0; mem_rd = 0;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [12:0] imm, input logic [31:0] pc);
        id_valid = 1; id_inst = make_br(f3, r1, r2, imm); id_pc = pc;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1;
        idle_inputs();
        @(posedge clk); #1;
        step();
        rst = 0;
        step();
        check("reset stall_id", {31'd0, last_stall}, 32'd0);
        check("reset redirect_pc", redirect_pc, 32'd0);

        // BEQ forwarded from EX, pc 0x100 + 16.
        drive_br(3'd0, 5'd1, 5'd2, 13'd16, 32'h100);
        fwd_a = 2'b10; ex_result = 5; fwd_b = 2'b00; rs2_data = 5;
        step();
        check("beq stall_id", {31'd0, last_stall}, 32'd0);
        check("beq redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("beq flush_if", {31'd0, flush_if}, 32'd1);
        check("beq redirect_pc", redirect_pc, 32'h110);
        idle_inputs(); step();

        // BLT vs BLTU on 0xFFFFFFFF and 1.
        drive_br(3'd4, 5'd1, 5'd2, 13'd8, 32'h200);
        rs1_data = 32'hFFFF_FFFF; rs2_data = 1;
        step();
        check("blt taken", {31'd0, redirect_valid}, 32'd1);
        check("blt redirect_pc", redirect_pc, 32'h208);
        idle_inputs(); step();
        drive_br(3'd6, 5'd1, 5'd2, 13'd8, 32'h300);
        rs1_data = 32'hFFFF_FFFF; rs2_data = 1;
        step();
        check("bltu not taken", {31'd0, redirect_valid}, 32'd0);
        idle_inputs(); step();

        // EX load-use: two stall cycles, resolve in the third.
        drive_br(3'd0, 5'd5, 5'd6, 13'd4, 32'h400);
        ex_is_load = 1; ex_rd = 5;
        step(); check("ex hz stall 1", {31'd0, last_stall}, 32'd1);
        step(); check("ex hz stall 2", {31'd0, last_stall}, 32'd1);
        step(); check("ex hz resolve", {31'd0, last_stall}, 32'd0);
        check("ex hz redirect", {31'd0, redirect_valid}, 32'd1);
        check("ex hz redirect_pc", redirect_pc, 32'h404);
        idle_inputs(); step();
        drive_br(3'd0, 5'd5, 5'd6, 13'd4, 32'h500);
        ex_is_load = 1; ex_rd = 0;
        step(); check("ex rd0 no stall", {31'd0, last_stall}, 32'd0);
        check("ex rd0 redirect", {31'd0, redirect_valid}, 32'd1);
        idle_inputs(); step();

        // Reset in the second stall cycle cancels the branch.
        drive_br(3'd0, 5'd5, 5'd6, 13'd4, 32'h600);
        ex_is_load = 1; ex_rd = 5;
        step();
        rst = 1; step();
        rst = 0; idle_inputs();
        check("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        step(); check("rst stall_id", {31'd0, last_stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); check("rst no late redirect", {31'd0, redirect_valid}, 32'd0);
        end

        // Illegal funct3 and target wrap.
        drive_br(3'd2, 5'd1, 5'd2, 13'd16, 32'h700);
        step();
        check("illegal pulse", {31'd0, illegal_br}, 32'd1);
        check("illegal no redirect", {31'd0, redirect_valid}, 32'd0);
        idle_inputs(); step();
        check("illegal one cycle", {31'd0, illegal_br}, 32'd0);
        drive_br(3'd0, 5'd1, 5'd2, 13'd32, 32'hFFFF_FFF0);
        step();
        check("wrap redirect_pc", redirect_pc, 32'h0000_0010);
        idle_inputs(); step();

`ifdef BRANCH_STATS_EN
        rst = 1; step(); rst = 0;
        drive_br(3'd0, 5'd5, 5'd6, 13'd4, 32'h800); ex_is_load = 1; ex_rd = 5;
        step(); step(); step();
        idle_inputs(); step();
        for (int i = 0; i < 2; i++) begin
            drive_br(3'd0, 5'd1, 5'd2, 13'd4, 32'h900); step();
            idle_inputs(); step();
        end
        for (int i = 0; i < 2; i++) begin
            drive_br(3'd1, 5'd1, 5'd2, 13'd4, 32'hA00); step();
        end
        idle_inputs(); step();
        check("br_taken_cnt", br_taken_cnt, 32'd3);
        check("br_ntaken_cnt", br_ntaken_cnt, 32'd2);
        check("br_stall_cnt", br_stall_cnt, 32'd2);
`endif

        // Randomized traffic; a stalled branch is usually held in ID like a real pipeline.
        for (int n = 0; n < 3000; n++) begin
            if (!(pending && $urandom_range(0, 15) != 0)) begin
                if ($urandom_range(0, 4) != 0) begin
                    drive_br(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 13'($urandom), $urandom);
                end else begin
                    id_inst = $urandom;
                    if (id_inst[6:0] == 7'b1100011) id_inst[2] = 1'b1;
                    id_pc = $urandom;
                end
            end
            id_valid    = ($urandom_range(0, 9) != 0);
            rs1_data    = pick_val();
            rs2_data    = $urandom_range(0, 2) == 0 ? rs1_data : pick_val();
            ex_result   = pick_val();
            mem_result  = pick_val();
            fwd_a       = 2'($urandom_range(0, 3));
            fwd_b       = 2'($urandom_range(0, 3));
            ex_is_load  = ($urandom_range(0, 3) == 0);
            mem_is_load = ($urandom_range(0, 3) == 0);
            ex_rd       = 5'($urandom_range(0, 7));
            mem_rd      = 5'($urandom_range(0, 7));
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
